id_stage_reg: RTL and testbench
===============================

Name: id_stage_reg

Overview:
- Second-generation instruction decode stage: a combinational RV32I(+M) field and control decoder behind a registered, valid/ready-handshaked pipeline register.
- Sits between the fetch stage and the execute stage.
- Adds capabilities the first decoder lacked: load-use hazard stall, flush, exact opcode matching, an illegal-opcode flag, optional multiply decode, and a halt state machine.

Parameters:
- XLEN, 32, width of the PC carried alongside each instruction.
- EN_MUL, 1, 1 = decode M-extension (funct7 = 7'b0000001 on R-type) into mult; 0 = mult is tied to 0.
- EN_HAZARD, 1, 1 = insert a load-use stall bubble; 0 = never stall, so the hazard is handled by an external forwarding unit.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  branch/jump redirect; kill held and incoming work
- out_valid  out  1  registered decode is valid
- out_ready  in  1  execute accepts the output
- out_instr  out  32  forwarded instruction, for immediate generation
- out_pc  out  XLEN  forwarded PC
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7]
- out_funct3  out  3  instr[14:12]
- out_funct7  out  7  instr[31:25]
- out_itype  out  3  opcode[6:4]
- out_reg_write, out_mem_reg, out_mem_write, out_alu_src, out_branch, out_jal, out_jalr, out_mult, out_illegal  out  1 each  control bits
- halted  out  1  a halt instruction has been handed to execute

Behaviour:
- Reset: out_valid=0, every out_* field=0, halted=0, state=RUN, load_pend=0, load_rd=0.
- Opcodes, exact 7-bit compare:
  - LOAD 0000011: mem_reg, reg_write, alu_src.
  - OPIMM 0010011: reg_write, alu_src.
  - STORE 0100011: mem_write, alu_src.
  - OP 0110011: reg_write; mult when EN_MUL and funct7 = 0000001.
  - BRANCH 1100011: branch.
  - JAL 1101111: jal, reg_write.
  - JALR 1100111: jalr, reg_write, alu_src.
  - HALT 1111111: all control bits 0.
  - Any other opcode: illegal=1 and all other control bits 0. The instruction still propagates; execute decides the trap.
- rd = x0: reg_write is still decoded as above; the register file ignores the write to x0.
- Latency: 1 cycle from the input handshake to out_valid.
- Handshake: a transfer occurs on valid&ready at the rising edge. No combinational path from in_valid to out_valid.
- in_ready = (!out_valid | out_ready) & state==RUN & !stall & !flush.
- Output register update each cycle:
  - If out_valid & out_ready and no input transfer, out_valid falls to 0.
  - Fields hold when out_valid & !out_ready.
  - Fields are don't-care but deterministic (hold last value) when out_valid=0.
- Load-use tracking:
  - On each output transfer: load_pend <= (opcode==LOAD & rd!=0), load_rd <= rd.
  - On any cycle without an output transfer: load_pend <= 0.
- Stall:
  - stall = EN_HAZARD & load_pend & in_valid & ((rs1==load_rd & rs1 used) | (rs2==load_rd & rs2 used)).
  - rs1 is used by OP, OPIMM, LOAD, STORE, BRANCH, JALR; rs2 by OP, STORE, BRANCH.
  - Exactly one bubble is inserted; load_pend clears, so the next cycle proceeds.
- State machine:
  - RUN -> HALTING when a HALT instruction is accepted on the input.
  - HALTING -> HALTED on the output transfer of that HALT; halted=1 from the following cycle.
  - HALTED is sticky until rst; in_ready=0 throughout.
- Flush (highest priority after rst):
  - out_valid <= 0, load_pend <= 0, no input accepted that cycle.
  - HALTING -> RUN, since the halt was speculative.
  - HALTED is unaffected.
- Flush and out_ready in the same cycle: flush wins; the held instruction is dropped.
- rst mid-operation overrides everything, including the HALTED state.

Decomposition:
- pipeline_pkg:
  - Opcode constants (OPC_LOAD, OPC_OPIMM, OPC_STORE, OPC_OP, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_HALT).
  - itype codes.
  - Halt-FSM state enum {RUN, HALTING, HALTED}.
  - MUL_FUNCT7 constant.
- Sub-module id_decode_comb: purely combinational instruction -> control/field decode, including the rs1/rs2-used flags.
- id_stage_reg contains only the register, hazard, handshake and FSM logic.

Test Plan:
- Reset, then stream ADDI x1,x0,5 (0x00500093), ADD x2,x1,x1 (0x00108133) with out_ready=1 -> each appears 1 cycle after acceptance. ADDI: reg_write=1, alu_src=1, itype=001. ADD: rs1=rs2=1, rd=2.
- LW x5,0(x6) then ADD x7,x5,x0, back-to-back -> in_ready=0 for exactly one cycle; out_valid has one-cycle gap; ADD emitted next. Repeat with EN_HAZARD=0 -> no gap.
- out_ready=0 for 3 cycles with valid output held -> out_* stable, in_ready=0. Release -> next instruction enters; no loss or duplication.
- MUL x3,x1,x2 (0x022081B3) -> mult=1 when EN_MUL=1, mult=0 when EN_MUL=0. Opcode 0x0B -> illegal=1, all other control bits 0.
- Accept HALT (0xFFFFFFFF), then flush before the output transfer -> out_valid=0, state RUN, halted=0, in_ready resumes.
- Accept HALT and drain it -> halted=1 the cycle after the output transfer; in_ready stays 0 for 20 cycles; rst clears halted.

Source files
------------

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Brief    : Shared opcodes, itype codes, control bundle and halt FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_HALT   = 7'b1111111;

  localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;

  // itype is opcode[6:4]; branch, jal and jalr share the control-flow code
  localparam logic [2:0] ITYPE_LOAD  = 3'b000;
  localparam logic [2:0] ITYPE_OPIMM = 3'b001;
  localparam logic [2:0] ITYPE_STORE = 3'b010;
  localparam logic [2:0] ITYPE_OP    = 3'b011;
  localparam logic [2:0] ITYPE_CTRL  = 3'b110;
  localparam logic [2:0] ITYPE_SYS   = 3'b111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HALTING = 2'd1,
    HALTED  = 2'd2
  } halt_state_e;

  typedef struct packed {
    logic reg_write;
    logic mem_reg;
    logic mem_write;
    logic alu_src;
    logic branch;
    logic jal;
    logic jalr;
    logic mult;
    logic illegal;
  } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/id_decode_comb.sv
`default_nettype none
// ============================================================================
// Module   : id_decode_comb
// Brief    : Combinational opcode -> control decode with register-use flags.
// Revision : 1.0 - initial release
// ============================================================================
module id_decode_comb
  import pipeline_pkg::*;
#(
  parameter bit EN_MUL = 1'b1
) (
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  output ctrl_t      ctrl,
  output logic       rs1_used,
  output logic       rs2_used,
  output logic       is_load,
  output logic       is_halt
);

  logic w_mul_match;

  generate
    if (EN_MUL) begin : g_mul
      assign w_mul_match = (funct7 == MUL_FUNCT7);
    end else begin : g_no_mul
      assign w_mul_match = 1'b0;
    end
  endgenerate

  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    is_load  = 1'b0;
    is_halt  = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        ctrl.mem_reg   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        rs1_used       = 1'b1;
        is_load        = 1'b1;
      end
      OPC_OPIMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        ctrl.mult      = w_mul_match;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      OPC_BRANCH: begin
        ctrl.branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      OPC_JAL: begin
        ctrl.jal       = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl.jalr      = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        rs1_used       = 1'b1;
      end
      OPC_HALT: is_halt = 1'b1;
      // unknown opcodes still flow down the pipe; execute raises the trap
      default:  ctrl.illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_reg
// Brief    : Decode pipeline register with load-use stall, flush and halt FSM.
// Revision : 1.0 - initial release
// ============================================================================
module id_stage_reg
  import pipeline_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit EN_MUL    = 1'b1,
  parameter bit EN_HAZARD = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_itype,
  output logic            out_reg_write,
  output logic            out_mem_reg,
  output logic            out_mem_write,
  output logic            out_alu_src,
  output logic            out_branch,
  output logic            out_jal,
  output logic            out_jalr,
  output logic            out_mult,
  output logic            out_illegal,
  output logic            halted
);

  ctrl_t           w_ctrl;
  ctrl_t           r_ctrl;
  logic            w_rs1_used, w_rs2_used, w_is_load, w_is_halt;
  logic            w_rs_hit, w_stall, w_in_xfer, w_out_xfer;
  logic            r_valid, r_is_load, r_load_pend;
  logic [4:0]      r_load_rd;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  halt_state_e     r_state, w_state_nxt;

  id_decode_comb #(.EN_MUL(EN_MUL)) u_decode (
    .opcode   (in_instr[6:0]),
    .funct7   (in_instr[31:25]),
    .ctrl     (w_ctrl),
    .rs1_used (w_rs1_used),
    .rs2_used (w_rs2_used),
    .is_load  (w_is_load),
    .is_halt  (w_is_halt)
  );

  assign w_rs_hit = (w_rs1_used && (in_instr[19:15] == r_load_rd)) ||
                    (w_rs2_used && (in_instr[24:20] == r_load_rd));
  assign w_stall  = EN_HAZARD && r_load_pend && in_valid && w_rs_hit;

  assign in_ready   = (!r_valid || out_ready) && (r_state == RUN) && !w_stall && !flush;
  assign w_in_xfer  = in_valid && in_ready;
  // a flush drops the held instruction even if execute is ready for it
  assign w_out_xfer = r_valid && out_ready && !flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (w_in_xfer && w_is_halt) w_state_nxt = HALTING;
      HALTING: begin
        if (flush)           w_state_nxt = RUN;
        else if (w_out_xfer) w_state_nxt = HALTED;
      end
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_ctrl      <= '0;
      r_is_load   <= 1'b0;
      r_load_pend <= 1'b0;
      r_load_rd   <= '0;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_load_pend <= 1'b0;
    end else begin
      if (w_in_xfer) begin
        r_valid   <= 1'b1;
        r_instr   <= in_instr;
        r_pc      <= in_pc;
        r_ctrl    <= w_ctrl;
        r_is_load <= w_is_load;
      end else if (w_out_xfer) begin
        r_valid <= 1'b0;
      end
      // pending only for the one cycle after a load leaves for execute
      r_load_pend <= w_out_xfer && r_is_load && (r_instr[11:7] != 5'd0);
      if (w_out_xfer) r_load_rd <= r_instr[11:7];
    end
  end

  assign out_valid     = r_valid;
  assign out_instr     = r_instr;
  assign out_pc        = r_pc;
  assign out_rs1       = r_instr[19:15];
  assign out_rs2       = r_instr[24:20];
  assign out_rd        = r_instr[11:7];
  assign out_funct3    = r_instr[14:12];
  assign out_funct7    = r_instr[31:25];
  assign out_itype     = r_instr[6:4];
  assign out_reg_write = r_ctrl.reg_write;
  assign out_mem_reg   = r_ctrl.mem_reg;
  assign out_mem_write = r_ctrl.mem_write;
  assign out_alu_src   = r_ctrl.alu_src;
  assign out_branch    = r_ctrl.branch;
  assign out_jal       = r_ctrl.jal;
  assign out_jalr      = r_ctrl.jalr;
  assign out_mult      = r_ctrl.mult;
  assign out_illegal   = r_ctrl.illegal;
  assign halted        = (r_state == HALTED);

endmodule
`default_nettype wire

// File: tb/tb_id_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_stage_reg
// Brief    : Scoreboarded bench; dut_a default params, dut_b EN_MUL=0/EN_HAZARD=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_stage_reg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [2:0]  itype;
    logic [8:0]  ctrl;   // {rw, mr, mw, as, br, jal, jalr, mul, ill}
  } obs_t;

  typedef struct {
    logic        sel;
    logic [31:0] instr;
    logic [8:0]  ctrl;
    logic [2:0]  itype;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [31:0] lw;
    logic [31:0] dep;
    logic [8:0]  ctrl;
    logic [2:0]  itype;
    int          waits;
  } hz_t;

  localparam int NV = 14;
  localparam int NH = 5;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, out_ready, sel;
  logic [31:0] in_instr, in_pc, pc_cnt;
  int          errors = 0;
  int          checks = 0;
  obs_t        sb[$];
  obs_t        mon_exp;
  vec_t        vecs[NV];
  hz_t         hz[NH];

  logic        a_in_valid, a_in_ready, a_out_valid, a_halted;
  logic        b_in_valid, b_in_ready, b_out_valid, b_halted;
  logic [31:0] a_instr, a_pc, b_instr, b_pc;
  logic [4:0]  a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
  logic [2:0]  a_f3, a_it, b_f3, b_it;
  logic [6:0]  a_f7, b_f7;
  logic        a_rw, a_mr, a_mw, a_as, a_br, a_jal, a_jalr, a_mul, a_ill;
  logic        b_rw, b_mr, b_mw, b_as, b_br, b_jal, b_jalr, b_mul, b_ill;
  obs_t        obs_a, obs_b, obs;
  logic        out_valid, in_ready, halted;

  always #5 clk = ~clk;

  assign a_in_valid = in_valid && !sel;
  assign b_in_valid = in_valid && sel;
  assign obs_a = {a_instr, a_pc, a_rs1, a_rs2, a_rd, a_f3, a_f7, a_it,
                  a_rw, a_mr, a_mw, a_as, a_br, a_jal, a_jalr, a_mul, a_ill};
  assign obs_b = {b_instr, b_pc, b_rs1, b_rs2, b_rd, b_f3, b_f7, b_it,
                  b_rw, b_mr, b_mw, b_as, b_br, b_jal, b_jalr, b_mul, b_ill};
  assign obs       = sel ? obs_b : obs_a;
  assign out_valid = sel ? b_out_valid : a_out_valid;
  assign in_ready  = sel ? b_in_ready : a_in_ready;
  assign halted    = sel ? b_halted : a_halted;

  id_stage_reg #(.XLEN(32), .EN_MUL(1'b1), .EN_HAZARD(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_instr), .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_rd(a_rd), .out_funct3(a_f3), .out_funct7(a_f7), .out_itype(a_it),
    .out_reg_write(a_rw), .out_mem_reg(a_mr), .out_mem_write(a_mw),
    .out_alu_src(a_as), .out_branch(a_br), .out_jal(a_jal), .out_jalr(a_jalr),
    .out_mult(a_mul), .out_illegal(a_ill), .halted(a_halted)
  );

  id_stage_reg #(.XLEN(32), .EN_MUL(1'b0), .EN_HAZARD(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_instr), .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_rd(b_rd), .out_funct3(b_f3), .out_funct7(b_f7), .out_itype(b_it),
    .out_reg_write(b_rw), .out_mem_reg(b_mr), .out_mem_write(b_mw),
    .out_alu_src(b_as), .out_branch(b_br), .out_jal(b_jal), .out_jalr(b_jalr),
    .out_mult(b_mul), .out_illegal(b_ill), .halted(b_halted)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic obs_t mk_exp(input logic [31:0] ins, input logic [31:0] pc,
                                  input logic [8:0] ctrl, input logic [2:0] it);
    obs_t e;
    e.instr  = ins;
    e.pc     = pc;
    e.rs1    = ins[19:15];
    e.rs2    = ins[24:20];
    e.rd     = ins[11:7];
    e.funct3 = ins[14:12];
    e.funct7 = ins[31:25];
    e.itype  = it;
    e.ctrl   = ctrl;
    return e;
  endfunction

  // present one instruction until accepted; expected output queued on acceptance
  task automatic send(input logic [31:0] ins, input logic [8:0] ctrl,
                      input logic [2:0] it, output int waits);
    logic acc;
    acc   = 1'b0;
    waits = 0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc_cnt;
      #1;
      acc = in_ready;
      @(posedge clk);
      if (acc) sb.push_back(mk_exp(ins, pc_cnt, ctrl, it));
      else     waits++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout instr=%h got=no_accept exp=accept", ins);
    end
    pc_cnt = pc_cnt + 32'd4;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int c;
    c = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (sb.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // output-side scoreboard: a transfer happens at the next rising edge
  always begin
    @(negedge clk);
    #2;
    if (!rst && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got=%h exp=none", obs);
      end else begin
        mon_exp = sb.pop_front();
        chk("out_fields", obs, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    vecs[0]  = '{1'b0, 32'h00500093, 9'b100100000, 3'b001}; // ADDI x1,x0,5
    vecs[1]  = '{1'b0, 32'h00108133, 9'b100000000, 3'b011}; // ADD x2,x1,x1
    vecs[2]  = '{1'b0, 32'h00032283, 9'b110100000, 3'b000}; // LW x5,0(x6)
    vecs[3]  = '{1'b0, 32'h00532223, 9'b001100000, 3'b010}; // SW x5,4(x6)
    vecs[4]  = '{1'b0, 32'h00208063, 9'b000010000, 3'b110}; // BEQ x1,x2
    vecs[5]  = '{1'b0, 32'h000000EF, 9'b100001000, 3'b110}; // JAL x1
    vecs[6]  = '{1'b0, 32'h000100E7, 9'b100100100, 3'b110}; // JALR x1,0(x2)
    vecs[7]  = '{1'b0, 32'h022081B3, 9'b100000010, 3'b011}; // MUL x3,x1,x2
    vecs[8]  = '{1'b0, 32'h0000000B, 9'b000000001, 3'b000}; // custom-0: illegal
    vecs[9]  = '{1'b0, 32'h00000017, 9'b000000001, 3'b001}; // AUIPC: not decoded
    vecs[10] = '{1'b0, 32'h00000033, 9'b100000000, 3'b011}; // ADD x0: rw kept
    vecs[11] = '{1'b1, 32'h022081B3, 9'b100000000, 3'b011}; // MUL without M
    vecs[12] = '{1'b1, 32'h00500093, 9'b100100000, 3'b001};
    vecs[13] = '{1'b1, 32'h0000000B, 9'b000000001, 3'b000};

    hz[0] = '{1'b0, 32'h00032283, 32'h000283B3, 9'b100000000, 3'b011, 1}; // ADD x7,x5,x0
    hz[1] = '{1'b1, 32'h00032283, 32'h000283B3, 9'b100000000, 3'b011, 0};
    hz[2] = '{1'b0, 32'h00032283, 32'h00532223, 9'b001100000, 3'b010, 1}; // SW uses rs2=x5
    hz[3] = '{1'b0, 32'h00032283, 32'h00500393, 9'b100100000, 3'b001, 0}; // ADDI: rs2 unused
    hz[4] = '{1'b0, 32'h00032003, 32'h000003B3, 9'b100000000, 3'b011, 0}; // LW to x0

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1; sel = 1'b0; pc_cnt = 32'h0000_1000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_fields_a", obs_a, '0);
    chk("rst_fields_b", obs_b, '0);
    chk("rst_valid_a", a_out_valid, 0);
    chk("rst_valid_b", b_out_valid, 0);
    chk("rst_halted_a", a_halted, 0);
    chk("rst_ready_a", a_in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].sel != sel) begin
        drain();
        @(negedge clk);
        sel = vecs[i].sel;
      end
      send(vecs[i].instr, vecs[i].ctrl, vecs[i].itype, w);
    end
    drain();

    for (int i = 0; i < NH; i++) begin
      @(negedge clk);
      sel = hz[i].sel;
      send(hz[i].lw, 9'b110100000, 3'b000, w);
      idle(1);
      send(hz[i].dep, hz[i].ctrl, hz[i].itype, w);
      chk($sformatf("stall_cycles_%0d", i), w, hz[i].waits);
      drain();
    end

    // backpressure: held output must stay put, no new acceptance
    @(negedge clk);
    sel = 1'b0;
    out_ready = 1'b0;
    send(32'h00500093, 9'b100100000, 3'b001, w);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = 32'h00108133;
      #1;
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_fields", obs, mk_exp(32'h00500093, pc_cnt - 32'd4, 9'b100100000, 3'b001));
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    send(32'h00108133, 9'b100000000, 3'b011, w);
    drain();

    // speculative halt squashed by flush, with execute ready at the same time
    @(negedge clk);
    out_ready = 1'b0;
    send(32'hFFFFFFFF, 9'b000000000, 3'b111, w);
    @(negedge clk);
    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("flush_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    #1;
    chk("flush_valid", out_valid, 0);
    chk("flush_halted", halted, 0);
    chk("flush_resume", in_ready, 1);
    send(32'h00500093, 9'b100100000, 3'b001, w);
    drain();
    chk("flush_still_run", halted, 0);

    // halt drained to execute
    send(32'hFFFFFFFF, 9'b000000000, 3'b111, w);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("halt_out_valid", out_valid, 1);
    chk("halt_not_yet", halted, 0);
    @(negedge clk);
    #1;
    chk("halted_set", halted, 1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = 32'h00500093;
      #1;
      chk("halted_no_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("halted_sticky_flush", halted, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_clears_halt", halted, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
